// File: rtl/mdu_ctrl_pkg.sv
// Shared types and constants for the RV64M multiply/divide sequencer.
// Build option MDU_DIV_FAST_EN is consumed by mdu_ctrl, not here.
package mdu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } mdu_state_t;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    typedef struct packed {
        logic [2:0]  funct3;
        logic        word32;
        logic [63:0] src_a;
        logic [63:0] src_b;
    } mdu_req_t;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Execute-stage <-> MDU handshake bundle; master is execute, slave is the MDU.
interface mdu_ctrl_if;
    logic        flush;
    logic        req;
    logic [2:0]  funct3;
    logic        word32;
    logic [63:0] src_a;
    logic [63:0] src_b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [63:0] result;

    modport master (
        output flush, req, funct3, word32, src_a, src_b,
        input  ready, busy, done, result
    );

    modport slave (
        input  flush, req, funct3, word32, src_a, src_b,
        output ready, busy, done, result
    );
endinterface

// File: rtl/mdu_ctrl_mul_pipe.sv
// MUL_LAT-stage 65x65 signed multiplier; operand regs are the first stage,
// so a product captured at edge t0 appears at o_prod in cycle t0+MUL_LAT.
module mdu_mul_pipe
    import mdu_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic         i_clk,
    input  logic [2:0]   i_funct3,
    input  logic [63:0]  i_a,
    input  logic [63:0]  i_b,
    output logic [127:0] o_prod
);

    logic               w_a_signed;
    logic               w_b_signed;
    logic signed [64:0] r_opa;
    logic signed [64:0] r_opb;
    logic signed [127:0] w_prod;

    assign w_a_signed = (i_funct3 == MDU_MULH) || (i_funct3 == MDU_MULHSU);
    assign w_b_signed = (i_funct3 == MDU_MULH);

    always_ff @(posedge i_clk) begin
        r_opa <= {w_a_signed & i_a[63], i_a};
        r_opb <= {w_b_signed & i_b[63], i_b};
    end

    assign w_prod = 128'(r_opa) * 128'(r_opb);

    generate
        if (MUL_LAT == 1) begin : g_comb
            assign o_prod = w_prod;
        end else begin : g_pipe
            logic [127:0] r_stage [MUL_LAT-1];

            always_ff @(posedge i_clk) begin
                r_stage[0] <= w_prod;
                for (int i = 1; i < MUL_LAT - 1; i++) begin
                    r_stage[i] <= r_stage[i-1];
                end
            end

            assign o_prod = r_stage[MUL_LAT-2];
        end
    endgenerate

endmodule

// File: rtl/mdu_ctrl.sv
// RV64M sequencer: pipelined multiply, radix-2 restoring divide, flushable.
// Build option MDU_DIV_FAST_EN: special-case divides bypass the iterations.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic     i_clk,
    input  logic     i_rst,
    mdu_ctrl_if.slave io_mdu
);

    localparam logic [5:0] MUL_LAT_C = 6'(MUL_LAT);

    mdu_state_t   r_state;
    mdu_state_t   w_next;
    mdu_req_t     r_req;
    logic [5:0]   r_cnt;
    logic [63:0]  r_quo;
    logic [63:0]  r_rem;
    logic         r_sign_q;
    logic         r_sign_r;
    logic         r_div0;
    logic         r_ovf;
    logic         r_busy;
    logic         r_done;
    logic [63:0]  r_result;

    logic         w_accept;
    logic         w_is_signed;
    logic [63:0]  w_a_ext;
    logic [63:0]  w_b_ext;
    logic         w_neg_a;
    logic         w_neg_b;
    logic [63:0]  w_mag_a;
    logic [63:0]  w_mag_b;
    logic         w_div0;
    logic         w_ovf;
    logic         w_fast;
    logic [64:0]  w_shift;
    logic         w_ge;
    logic [63:0]  w_diff;
    logic [127:0] w_prod;
    logic [63:0]  w_mul_res;
    logic [63:0]  w_quo;
    logic [63:0]  w_rem;
    logic [63:0]  w_div_raw;
    logic [63:0]  w_div_res;
    logic [63:0]  w_res;

    mdu_mul_pipe #(.MUL_LAT(MUL_LAT)) u_mul (
        .i_clk    (i_clk),
        .i_funct3 (io_mdu.funct3),
        .i_a      (io_mdu.src_a),
        .i_b      (io_mdu.src_b),
        .o_prod   (w_prod)
    );

    // Operand conditioning for the divider, evaluated on the accept cycle
    assign w_accept    = (r_state == IDLE) && io_mdu.req && !io_mdu.flush;
    assign w_is_signed = !io_mdu.funct3[0];
    assign w_a_ext = !io_mdu.word32 ? io_mdu.src_a :
                     w_is_signed    ? sext32(io_mdu.src_a[31:0]) : {32'b0, io_mdu.src_a[31:0]};
    assign w_b_ext = !io_mdu.word32 ? io_mdu.src_b :
                     w_is_signed    ? sext32(io_mdu.src_b[31:0]) : {32'b0, io_mdu.src_b[31:0]};
    assign w_neg_a = w_is_signed && w_a_ext[63];
    assign w_neg_b = w_is_signed && w_b_ext[63];
    assign w_mag_a = w_neg_a ? -w_a_ext : w_a_ext;
    assign w_mag_b = w_neg_b ? -w_b_ext : w_b_ext;
    assign w_div0  = (w_b_ext == '0);
    assign w_ovf   = w_is_signed && (w_b_ext == '1) &&
                     (w_a_ext == (io_mdu.word32 ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));

`ifdef MDU_DIV_FAST_EN
    assign w_fast = w_div0 || w_ovf || (w_a_ext == '0);
`else
    assign w_fast = 1'b0;
`endif

    // One restoring step; src_b of the latched request holds the divisor magnitude
    assign w_shift = {r_rem, r_quo[63]};
    assign w_ge    = (w_shift >= {1'b0, r_req.src_b});
    assign w_diff  = w_shift[63:0] - r_req.src_b;

    assign w_mul_res = r_req.word32 ? sext32(w_prod[31:0]) :
                       (r_req.funct3 == MDU_MUL) ? w_prod[63:0] : w_prod[127:64];

    always_comb begin
        w_quo = r_sign_q ? -r_quo : r_quo;
        w_rem = r_sign_r ? -r_rem : r_rem;
        if (r_div0) begin
            w_quo = '1;
            w_rem = r_req.src_a;
        end else if (r_ovf) begin
            w_quo = r_req.src_a;
            w_rem = '0;
        end
        w_div_raw = r_req.funct3[1] ? w_rem : w_quo;
        w_div_res = r_req.word32 ? sext32(w_div_raw[31:0]) : w_div_raw;
        w_res     = (r_state == MUL) ? w_mul_res : w_div_res;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (io_mdu.req) w_next = !io_mdu.funct3[2] ? MUL : (w_fast ? FIX : DIV);
            MUL:  if (r_cnt == MUL_LAT_C) w_next = DONE;
            DIV:  if (r_cnt == 6'd0) w_next = FIX;
            FIX:  w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (io_mdu.flush) w_next = IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Counter counts up through the multiplier latency, down through divide steps
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_busy <= (w_next != IDLE);
            r_done <= (w_next == DONE);
            if (w_next == DONE) r_result <= w_res;
            if (w_accept)
                r_cnt <= !io_mdu.funct3[2] ? 6'd1 : (io_mdu.word32 ? 6'd31 : 6'd63);
            else if (r_state == MUL && w_next == MUL)
                r_cnt <= r_cnt + 6'd1;
            else if (r_state == DIV && w_next == DIV)
                r_cnt <= r_cnt - 6'd1;
            else
                r_cnt <= '0;
        end
    end

    // W-form dividends are pre-shifted so the next bit is always quo[63]
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_req    <= '{funct3: io_mdu.funct3, word32: io_mdu.word32, src_a: w_a_ext, src_b: w_mag_b};
            r_quo    <= io_mdu.word32 ? {w_mag_a[31:0], 32'b0} : w_mag_a;
            r_rem    <= '0;
            r_sign_q <= w_neg_a ^ w_neg_b;
            r_sign_r <= w_neg_a;
            r_div0   <= w_div0;
            r_ovf    <= w_ovf;
        end else if (r_state == DIV) begin
            r_rem <= w_ge ? w_diff : w_shift[63:0];
            r_quo <= {r_quo[62:0], w_ge};
        end
    end

    assign io_mdu.ready  = !io_mdu.req || r_done;
    assign io_mdu.busy   = r_busy;
    assign io_mdu.done   = r_done;
    assign io_mdu.result = r_result;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed plan steps, then random ops
// scored against an arithmetic reference model. Honours MDU_DIV_FAST_EN.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    localparam int MUL_LAT = 2;
    localparam int LIMIT   = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] lastRes = '0;

    mdu_ctrl_if io();

    mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_mdu (io)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ISA-level reference: plain 128-bit products and SV division operators
    function automatic logic [63:0] refModel(input logic [2:0] f, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
        logic [127:0]       p;
        logic [63:0]        q;
        logic [63:0]        r;
        logic [31:0]        q32;
        logic [31:0]        r32;
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [31:0] sa32;
        logic signed [31:0] sb32;
        if (!f[2]) begin
            case (f)
                3'b001:  p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
                3'b010:  p = {{64{a[63]}}, a} * {64'b0, b};
                default: p = {64'b0, a} * {64'b0, b};
            endcase
            if (w) return {{32{p[31]}}, p[31:0]};
            return (f == 3'b000) ? p[63:0] : p[127:64];
        end
        if (w) begin
            sa32 = a[31:0];
            sb32 = b[31:0];
            if (b[31:0] == 32'd0) begin
                q32 = '1;
                r32 = a[31:0];
            end else if (f[0]) begin
                q32 = a[31:0] / b[31:0];
                r32 = a[31:0] % b[31:0];
            end else if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
                q32 = a[31:0];
                r32 = '0;
            end else begin
                q32 = sa32 / sb32;
                r32 = sa32 % sb32;
            end
            return f[1] ? {{32{r32[31]}}, r32} : {{32{q32[31]}}, q32};
        end
        sa = a;
        sb = b;
        if (b == 64'd0) begin
            q = '1;
            r = a;
        end else if (f[0]) begin
            q = a / b;
            r = a % b;
        end else if (a == 64'h8000_0000_0000_0000 && b == '1) begin
            q = a;
            r = '0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        return f[1] ? r : q;
    endfunction

    function automatic int refLatency(input logic [2:0] f, input logic w,
                                      input logic [63:0] a, input logic [63:0] b);
`ifdef MDU_DIV_FAST_EN
        logic fast;
`endif
        if (!f[2]) return MUL_LAT + 1;
`ifdef MDU_DIV_FAST_EN
        if (w) fast = (b[31:0] == 0) || (a[31:0] == 0) ||
                      (!f[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        else   fast = (b == 0) || (a == 0) ||
                      (!f[0] && a == 64'h8000_0000_0000_0000 && b == '1);
        if (fast) return 2;
`endif
        return w ? 34 : 66;
    endfunction

    function automatic logic [63:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'(-$urandom_range(0, 20));
            4:       return {32'hFFFF_FFFF, 32'h8000_0000};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Called at a negedge; a call made in a DONE cycle is a back-to-back issue
    task automatic applyStimulus(input string tag, input logic [2:0] f, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
        int          lat;
        int          k;
        logic [63:0] exp;
        logic        readyOk;
        logic        busyOk;
        logic        b2b;
        exp = refModel(f, w, a, b);
        lat = refLatency(f, w, a, b);
        b2b = io.done;
        io.req    = 1'b1;
        io.funct3 = f;
        io.word32 = w;
        io.src_a  = a;
        io.src_b  = b;
        if (b2b) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        checkOutput({tag, "/acc_ready"}, 64'(io.ready), 64'd0);
        readyOk = 1'b1;
        busyOk  = 1'b1;
        k = 0;
        while (k < LIMIT) begin
            @(posedge clk);
            @(negedge clk);
            k++;
            if (io.done) break;
            if (io.ready !== 1'b0) readyOk = 1'b0;
            if (io.busy !== 1'b1) busyOk = 1'b0;
        end
        checkOutput({tag, "/latency"}, 64'(k), 64'(lat));
        checkOutput({tag, "/result"}, io.result, exp);
        checkOutput({tag, "/ctl"}, {60'd0, readyOk, busyOk, io.ready, io.busy}, 64'hF);
        lastRes = exp;
    endtask

    task automatic idle(input int n);
        io.req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("idle/done_busy", {62'd0, io.done, io.busy}, 64'd0);
        repeat (n - 1) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [2:0] f;
        logic       w;

        io.flush = 1'b0;
        io.req   = 1'b0;
        io.funct3 = '0;
        io.word32 = 1'b0;
        io.src_a  = '0;
        io.src_b  = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset/state", {61'd0, io.busy, io.done, io.ready}, 64'd1);
        checkOutput("reset/result", io.result, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        applyStimulus("mulh", MDU_MULH, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3);
        idle(2);
        applyStimulus("div", MDU_DIV, 1'b0, 64'(-7), 64'd2);
        idle(1);
        applyStimulus("rem", MDU_REM, 1'b0, 64'(-7), 64'd2);
        idle(1);
        applyStimulus("divw_ovf", MDU_DIV, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF);
        idle(1);
        applyStimulus("divu_zero", MDU_DIVU, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd0);
        idle(1);

        $display("[TB] flush during divide");
        io.req = 1'b1; io.funct3 = MDU_DIV; io.word32 = 1'b0;
        io.src_a = 64'd1000; io.src_b = 64'd7;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput("flush/pre_busy", {62'd0, io.busy, io.done}, 64'd2);
        io.flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        io.flush = 1'b0;
        io.req   = 1'b0;
        checkOutput("flush/post", {62'd0, io.busy, io.done}, 64'd0);
        checkOutput("flush/result_held", io.result, lastRes);
        @(posedge clk);
        @(negedge clk);
        applyStimulus("flush/mul_after", MDU_MUL, 1'b0, 64'h0000_0001_0000_0003, 64'h0000_0000_0000_0005);

        $display("[TB] back-to-back MUL then REMU");
        idle(1);
        applyStimulus("b2b/mul", MDU_MUL, 1'b0, 64'hDEAD_BEEF, 64'h1_0000);
        applyStimulus("b2b/remu", MDU_REMU, 1'b0, 64'd1_000_003, 64'd97);
        idle(1);

        $display("[TB] reset mid-divide");
        io.req = 1'b1; io.funct3 = MDU_DIV; io.word32 = 1'b0;
        io.src_a = 64'd12345; io.src_b = 64'd17;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst/mid_div", {62'd0, io.busy, io.done}, 64'd0);
        checkOutput("rst/result", io.result, 64'd0);
        rst = 1'b1;
        io.req = 1'b0;
        lastRes = '0;
        @(negedge clk);

        $display("[TB] random operations");
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            w = 1'($urandom_range(0, 1));
            applyStimulus($sformatf("rnd%0d_f%0d_w%0d", i, f, w), f, w, pickOperand(), pickOperand());
            if ($urandom_range(0, 1) == 1) idle(1 + $urandom_range(0, 2));
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
